// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - PC sequencer: in-order fetch buffer, redirect squashing
// Optional fetch-time JAL redirection is enabled by defining PC_SEQ_JAL_PREDECODE_EN.
module pc_sequencer #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned     DEPTH        = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic            req_valid,
    output logic [XLEN-1:0] req_pc,
    input  logic            req_ready,
    input  logic            rsp_valid,
    input  logic [31:0]     rsp_instr,
    output logic            out_valid,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_instr,
    output logic            out_jal,
    input  logic            out_ready,
    input  logic            redir_valid,
    input  logic [XLEN-1:0] redir_pc
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    logic [XLEN-1:0]  pc_mem_q    [DEPTH];
    logic [31:0]      instr_mem_q [DEPTH];
    logic [DEPTH-1:0] filled_q;
    logic [CW-1:0]    head_q, fill_q, tail_q, drop_q;
    logic [CW-1:0]    head_d, fill_d, tail_d, drop_d;
    logic [XLEN-1:0]  req_pc_q, req_pc_d;

    logic [PW-1:0]    head_idx, fill_idx, tail_idx;
    logic [CW-1:0]    occupancy, unfilled;
    logic             req_fire, rsp_drop, rsp_write, pop;
    logic             jal_hit;
    logic [XLEN-1:0]  jal_target;
    logic [1:0]       redir_lsb_unused;

    assign head_idx = head_q[PW-1:0];
    assign fill_idx = fill_q[PW-1:0];
    assign tail_idx = tail_q[PW-1:0];
    assign redir_lsb_unused = redir_pc[1:0];

    // Wrong-path fetches still outstanding count against the in-flight limit,
    // which keeps drop_q bounded by DEPTH.
    assign occupancy = (tail_q - head_q) + drop_q;
    assign unfilled  = tail_q - fill_q;

    assign req_valid = (occupancy < DEPTH_C) && !redir_valid && !rst;
    assign req_pc    = req_pc_q;
    assign req_fire  = req_valid && req_ready;
    assign rsp_drop  = rsp_valid && (drop_q != '0);
    assign rsp_write = rsp_valid && (drop_q == '0) && (unfilled != '0);

    assign out_valid = filled_q[head_idx] && !redir_valid;
    assign out_pc    = pc_mem_q[head_idx];
    assign out_instr = instr_mem_q[head_idx];
    assign pop       = out_valid && out_ready;

`ifdef PC_SEQ_JAL_PREDECODE_EN
    logic [DEPTH-1:0] jal_q;
    assign jal_hit    = rsp_write && !redir_valid && (rsp_instr[6:0] == 7'b1101111);
    assign jal_target = pc_mem_q[fill_idx] + {{(XLEN-20){rsp_instr[31]}}, rsp_instr[19:12],
                                              rsp_instr[20], rsp_instr[30:21], 1'b0};
    assign out_jal    = jal_q[head_idx];
`else
    assign jal_hit    = 1'b0;
    assign jal_target = '0;
    assign out_jal    = 1'b0;
`endif

    always_comb begin
        head_d   = head_q;
        fill_d   = fill_q;
        tail_d   = tail_q;
        drop_d   = drop_q;
        req_pc_d = req_pc_q;
        if (redir_valid) begin
            head_d   = '0;
            fill_d   = '0;
            tail_d   = '0;
            drop_d   = drop_q + unfilled + CW'(req_fire) - CW'(rsp_drop || rsp_write);
            req_pc_d = {redir_pc[XLEN-1:2], 2'b00};
        end else begin
            if (rsp_drop)  drop_d = drop_q - ONE_C;
            if (req_fire) begin
                tail_d   = tail_q + ONE_C;
                req_pc_d = req_pc_q + XLEN'(4);
            end
            if (rsp_write) fill_d = fill_q + ONE_C;
            if (pop)       head_d = head_q + ONE_C;
            // Everything younger than the JAL, including this cycle's request, is wrong-path.
            if (jal_hit) begin
                tail_d   = fill_q + ONE_C;
                drop_d   = drop_q + (unfilled - ONE_C) + CW'(req_fire);
                req_pc_d = jal_target;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q   <= '0;
            fill_q   <= '0;
            tail_q   <= '0;
            drop_q   <= '0;
            req_pc_q <= RESET_VECTOR;
            filled_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= '0;
            end
        end else begin
            head_q   <= head_d;
            fill_q   <= fill_d;
            tail_q   <= tail_d;
            drop_q   <= drop_d;
            req_pc_q <= req_pc_d;
            if (redir_valid) begin
                filled_q <= '0;
            end else begin
                if (req_fire) begin
                    pc_mem_q[tail_idx] <= req_pc_q;
                    filled_q[tail_idx] <= 1'b0;
                end
                if (rsp_write) begin
                    instr_mem_q[fill_idx] <= rsp_instr;
                    filled_q[fill_idx]    <= 1'b1;
                end
                if (pop) filled_q[head_idx] <= 1'b0;
            end
        end
    end

`ifdef PC_SEQ_JAL_PREDECODE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            jal_q <= '0;
        end else if (redir_valid) begin
            jal_q <= '0;
        end else begin
            if (req_fire)  jal_q[tail_idx] <= 1'b0;
            if (rsp_write) jal_q[fill_idx] <= jal_hit;
        end
    end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer
module tb_pc_sequencer;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RV    = 32'h100;

    logic        clk = 1'b0;
    logic        rst, req_valid, req_ready, rsp_valid, out_valid, out_jal, out_ready, redir_valid;
    logic [31:0] req_pc, rsp_instr, out_pc, out_instr, redir_pc;

    int total = 0;
    int bad   = 0;

    typedef struct { logic [31:0] pc; int t; } mreq_t;
    mreq_t       mq[$];
    int          cyc = 0;
    bit          mem_hold, mem_rand, nop_mode, jal_en;
    logic [31:0] jal_pc;

    logic        s_req_valid, s_req_fire, s_out_valid, s_out_fire, s_out_jal;
    logic [31:0] s_req_pc, s_out_pc, s_out_instr;

    pc_sequencer #(.XLEN(32), .RESET_VECTOR(RV), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_pc(req_pc), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_instr(rsp_instr),
        .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr), .out_jal(out_jal),
        .out_ready(out_ready),
        .redir_valid(redir_valid), .redir_pc(redir_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return {pc[26:2], 7'b0010011};
    endfunction

    function automatic logic [31:0] mem_instr(input logic [31:0] pc);
        if (nop_mode) return 32'h0000_0013;
        if (jal_en && pc == jal_pc) return 32'h0080_006F;
        return instr_of(pc);
    endfunction

    // In-order memory: answers the oldest accepted request no earlier than the next cycle.
    task automatic cycle();
        rsp_valid = 1'b0;
        rsp_instr = '0;
        if (!mem_hold && mq.size() > 0 && mq[0].t < cyc && (!mem_rand || $urandom_range(0, 2) != 0)) begin
            rsp_valid = 1'b1;
            rsp_instr = mem_instr(mq[0].pc);
        end
        #1;
        s_req_valid = req_valid;
        s_req_pc    = req_pc;
        s_req_fire  = req_valid & req_ready;
        s_out_valid = out_valid;
        s_out_fire  = out_valid & out_ready;
        s_out_pc    = out_pc;
        s_out_instr = out_instr;
        s_out_jal   = out_jal;
        @(posedge clk);
        if (rsp_valid) void'(mq.pop_front());
        if (s_req_fire) mq.push_back('{pc: s_req_pc, t: cyc});
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_ready = 1'b0; out_ready = 1'b0; redir_valid = 1'b0; redir_pc = '0;
        rsp_valid = 1'b0; rsp_instr = '0;
        mem_hold = 0; mem_rand = 0; nop_mode = 0; jal_en = 0; jal_pc = '0;
        mq.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_ready = 1'b1; out_ready = 1'b1; redir_valid = 1'b0; redir_pc = '0;
        rsp_valid = 1'b0; rsp_instr = '0;
        @(negedge clk); #1;
        total++; if (req_valid !== 1'b0)  begin bad++; $display("FAIL reset_req_valid: got %b exp 0", req_valid); end
        total++; if (req_pc !== RV)       begin bad++; $display("FAIL reset_req_pc: got %h exp %h", req_pc, RV); end
        total++; if (out_valid !== 1'b0)  begin bad++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
        total++; if (out_pc !== 32'h0)    begin bad++; $display("FAIL reset_out_pc: got %h exp 0", out_pc); end
        total++; if (out_instr !== 32'h0) begin bad++; $display("FAIL reset_out_instr: got %h exp 0", out_instr); end
        total++; if (out_jal !== 1'b0)    begin bad++; $display("FAIL reset_out_jal: got %b exp 0", out_jal); end
    endtask

    task automatic test_sequential();
        do_reset();
        req_ready = 1'b1; out_ready = 1'b1; nop_mode = 1;
        for (int k = 0; k < 8; k++) begin
            cycle();
            total++; if (s_req_valid !== 1'b1 || s_req_pc !== RV + 32'(4 * k))
                begin bad++; $display("FAIL seq_req[%0d]: got v=%b pc=%h exp pc %h", k, s_req_valid, s_req_pc, RV + 32'(4 * k)); end
            total++; if (s_out_valid !== (k >= 2))
                begin bad++; $display("FAIL seq_out_valid[%0d]: got %b exp %b", k, s_out_valid, k >= 2); end
            if (k >= 2) begin
                total++; if (s_out_pc !== RV + 32'(4 * (k - 2)) || s_out_instr !== 32'h13)
                    begin bad++; $display("FAIL seq_out[%0d]: got pc=%h instr=%h exp pc=%h instr=13", k, s_out_pc, s_out_instr, RV + 32'(4 * (k - 2))); end
            end
        end
    endtask

    task automatic test_backpressure();
        int   fires = 0;
        bit   got   = 0;
        logic [31:0] first_req = '0;
        do_reset();
        req_ready = 1'b1; out_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            cycle();
            if (s_req_fire) fires++;
        end
        total++; if (fires != DEPTH) begin bad++; $display("FAIL bp_fires: got %0d exp %0d", fires, DEPTH); end
        total++; if (s_req_valid !== 1'b0) begin bad++; $display("FAIL bp_full_req_valid: got %b exp 0", s_req_valid); end
        total++; if (s_out_valid !== 1'b1 || s_out_pc !== RV)
            begin bad++; $display("FAIL bp_head: got v=%b pc=%h exp v=1 pc=%h", s_out_valid, s_out_pc, RV); end
        out_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            cycle();
            if (k < 4) begin
                total++; if (s_out_fire !== 1'b1 || s_out_pc !== RV + 32'(4 * k) || s_out_instr !== instr_of(RV + 32'(4 * k)))
                    begin bad++; $display("FAIL bp_drain[%0d]: got fire=%b pc=%h instr=%h exp pc=%h", k, s_out_fire, s_out_pc, s_out_instr, RV + 32'(4 * k)); end
            end
            if (s_req_fire && !got) begin got = 1; first_req = s_req_pc; end
        end
        total++; if (!got || first_req !== RV + 32'h10)
            begin bad++; $display("FAIL bp_resume: got seen=%0d pc=%h exp pc=%h", got, first_req, RV + 32'h10); end
    endtask

    task automatic test_redirect();
        int   fires = 0;
        int   nout  = 0;
        logic [31:0] outs[2];
        do_reset();
        req_ready = 1'b1; out_ready = 1'b1; mem_hold = 1;
        repeat (3) begin cycle(); if (s_req_fire) fires++; end
        total++; if (fires != 3) begin bad++; $display("FAIL redir_inflight: got %0d exp 3", fires); end
        redir_valid = 1'b1; redir_pc = 32'h2003;
        cycle();
        redir_valid = 1'b0;
        total++; if (s_req_valid !== 1'b0 || s_out_valid !== 1'b0)
            begin bad++; $display("FAIL redir_gate: got req_valid=%b out_valid=%b exp 0 0", s_req_valid, s_out_valid); end
        mem_hold = 0;
        cycle();
        total++; if (s_req_valid !== 1'b1 || s_req_pc !== 32'h2000)
            begin bad++; $display("FAIL redir_first_req: got v=%b pc=%h exp v=1 pc=2000", s_req_valid, s_req_pc); end
        for (int k = 0; k < 20 && nout < 2; k++) begin
            cycle();
            if (s_out_fire) begin
                total++; if (s_out_instr !== instr_of(s_out_pc))
                    begin bad++; $display("FAIL redir_pair_instr: got %h exp %h for pc %h", s_out_instr, instr_of(s_out_pc), s_out_pc); end
                outs[nout] = s_out_pc; nout++;
            end
        end
        total++; if (nout != 2 || outs[0] !== 32'h2000 || outs[1] !== 32'h2004)
            begin bad++; $display("FAIL redir_out_seq: got n=%0d pcs=%h %h exp 2000 2004", nout, outs[0], outs[1]); end
    endtask

    task automatic test_redirect_collision();
        int n = 0;
        do_reset();
        req_ready = 1'b1; out_ready = 1'b1;
        repeat (5) cycle();
        redir_valid = 1'b1; redir_pc = 32'h4000;
        cycle();
        redir_valid = 1'b0;
        total++; if (s_req_valid !== 1'b0 || s_out_valid !== 1'b0)
            begin bad++; $display("FAIL coll_gate: got req_valid=%b out_valid=%b exp 0 0", s_req_valid, s_out_valid); end
        for (int k = 0; k < 15; k++) begin
            cycle();
            if (s_out_fire) begin
                total++; if (s_out_pc !== 32'h4000 + 32'(4 * n) || s_out_instr !== instr_of(32'h4000 + 32'(4 * n)))
                    begin bad++; $display("FAIL coll_pair[%0d]: got pc=%h instr=%h exp pc=%h", n, s_out_pc, s_out_instr, 32'h4000 + 32'(4 * n)); end
                n++;
            end
        end
        total++; if (n < 3) begin bad++; $display("FAIL coll_progress: got %0d pairs exp >=3", n); end
    endtask

    task automatic test_jal();
        logic [31:0] exp_pc[7];
        logic        exp_jal[7];
        logic [31:0] e = RV;
        int          n = 0;
        for (int i = 0; i < 7; i++) begin
            exp_pc[i] = e;
`ifdef PC_SEQ_JAL_PREDECODE_EN
            exp_jal[i] = (e == 32'h110);
            e = (e == 32'h110) ? e + 32'h8 : e + 32'h4;
`else
            exp_jal[i] = 1'b0;
            e = e + 32'h4;
`endif
        end
        do_reset();
        jal_en = 1; jal_pc = 32'h110;
        req_ready = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            cycle();
            if (s_out_fire && n < 7) begin
                total++; if (s_out_pc !== exp_pc[n] || s_out_jal !== exp_jal[n] || s_out_instr !== mem_instr(exp_pc[n]))
                    begin bad++; $display("FAIL jal_pair[%0d]: got pc=%h jal=%b instr=%h exp pc=%h jal=%b", n, s_out_pc, s_out_jal, s_out_instr, exp_pc[n], exp_jal[n]); end
                n++;
            end
        end
        total++; if (n != 7) begin bad++; $display("FAIL jal_progress: got %0d pairs exp 7", n); end
    endtask

    task automatic test_reset_mid();
        int fires = 0;
        do_reset();
        req_ready = 1'b1; out_ready = 1'b0; mem_hold = 1;
        repeat (2) cycle();
        redir_valid = 1'b1; redir_pc = 32'h3000;
        cycle();
        redir_valid = 1'b0;
        repeat (3) begin cycle(); if (s_req_fire) fires++; end
        total++; if (fires != 2 || s_req_valid !== 1'b0)
            begin bad++; $display("FAIL rmid_full: got fires=%0d req_valid=%b exp 2 0", fires, s_req_valid); end
        #2 rst = 1'b1;
        #1;
        total++; if (req_valid !== 1'b0 || req_pc !== RV)
            begin bad++; $display("FAIL rmid_req: got v=%b pc=%h exp v=0 pc=%h", req_valid, req_pc, RV); end
        total++; if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_instr !== 32'h0 || out_jal !== 1'b0)
            begin bad++; $display("FAIL rmid_out: got v=%b pc=%h instr=%h jal=%b exp all 0", out_valid, out_pc, out_instr, out_jal); end
        @(negedge clk);
        mq.delete();
        mem_hold = 0;
        rst = 1'b0;
        cycle();
        total++; if (s_req_valid !== 1'b1 || s_req_pc !== RV)
            begin bad++; $display("FAIL rmid_restart: got v=%b pc=%h exp v=1 pc=%h", s_req_valid, s_req_pc, RV); end
    endtask

    // Reference: fetch and delivery are each a PC stream that steps by 4 and restarts at every redirect.
    task automatic test_random();
        logic [31:0] exp_fetch, exp_out, tgt;
        int          delivered = 0;
        bit          redir;
        do_reset();
        exp_fetch = RV; exp_out = RV; mem_rand = 1;
        for (int i = 0; i < 3000; i++) begin
            req_ready = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 4) != 0);
            redir = ($urandom_range(0, 39) == 0) || (redir_valid && $urandom_range(0, 2) == 0);
            tgt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            redir_valid = redir; redir_pc = tgt;
            cycle();
            if (redir) begin
                total++; if (s_req_valid !== 1'b0 || s_out_valid !== 1'b0)
                    begin bad++; $display("FAIL rand_redir_gate@%0d: got req_valid=%b out_valid=%b exp 0 0", i, s_req_valid, s_out_valid); end
                exp_fetch = {tgt[31:2], 2'b00};
                exp_out   = exp_fetch;
            end else begin
                if (s_req_valid) begin
                    total++; if (s_req_pc !== exp_fetch)
                        begin bad++; $display("FAIL rand_req_pc@%0d: got %h exp %h", i, s_req_pc, exp_fetch); end
                end
                if (s_out_fire) begin
                    total++; if (s_out_pc !== exp_out || s_out_instr !== instr_of(exp_out) || s_out_jal !== 1'b0)
                        begin bad++; $display("FAIL rand_pair@%0d: got pc=%h instr=%h jal=%b exp pc=%h instr=%h", i, s_out_pc, s_out_instr, s_out_jal, exp_out, instr_of(exp_out)); end
                    delivered++;
                    exp_out = exp_out + 32'h4;
                end
                if (s_req_fire) exp_fetch = exp_fetch + 32'h4;
            end
        end
        redir_valid = 1'b0;
        total++; if (delivered < 200) begin bad++; $display("FAIL rand_progress: got %0d pairs exp >=200", delivered); end
    endtask

    initial begin
        rst = 1'b1; req_ready = 1'b0; out_ready = 1'b0; redir_valid = 1'b0; redir_pc = '0;
        rsp_valid = 1'b0; rsp_instr = '0;
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect();
        test_redirect_collision();
        test_jal();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
